// File: rtl/multiword_add_pkg.sv
// multiword_add_pkg: shared types and constants for the
// nibble-serial multi-word add/sub sequencer.
package multiword_add_pkg;

  localparam int NIBBLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int k_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multiword_add_seq_adder.sv
// parallel_adder_4: 4-bit ripple-carry adder shared by the
// multi-word sequencer as its only arithmetic datapath.
module parallel_adder_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];

endmodule

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: wide add/sub done one nibble per cycle,
// LSB first, through a single 4-bit ripple adder.
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = k_width(NIBBLES);

  state_t        state;
  logic [KW-1:0] k;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  sum_r;
  logic          carry_r;
  logic          cout_r;
  logic          ovf_r;

  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [3:0]    sn;
  logic          co;
  logic          last;

  assign a_sh = a_r >> {k, 2'b00};
  assign b_sh = b_r >> {k, 2'b00};
  assign last = (k == KW'(NIBBLES - 1));

  parallel_adder_4 u_add (
    .a  (a_sh[3:0]),
    .b  (b_sh[3:0]),
    .ci (carry_r),
    .s  (sn),
    .co (co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub | cin;
            k       <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_r[{k, 2'b00} +: 4] <= sn;
          carry_r                <= co;
          if (last) begin
            cout_r <= co;
            // b_r already holds ~B for sub, so one rule fits both
            ovf_r  <= (a_r[W-1] == b_r[W-1]) && (sn[3] != a_r[W-1]);
            state  <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE) && !rst;
  assign res_valid = (state == DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq: vector table plus scoreboard bench for
// the nibble-serial add/sub sequencer (NIBBLES=4).
module tb_multiword_add_seq;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    exp_t        e;
  } vec_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  multiword_add_seq #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %h expected none", sum);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.co));
        chk("ovf", 32'(ovf), 32'(e.ov));
      end
    end
  end

  task automatic send(input vec_t v, input bit lat_chk);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    a   = v.a;
    b   = v.b;
    cin = v.cin;
    sub = v.sub;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    chk("accept_timeout", 32'(n < 50), 32'd1);
    q.push_back(v.e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (res_valid) break;
      @(posedge clk);
    end
    if (lat_chk) chk("latency", 32'(n), 32'(N));
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 50; n++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    vec_t v;
    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0}};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}};
    tbl[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, '{16'h8000, 1'b0, 1'b1}};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}};
    tbl[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
    tbl[5] = '{16'h0007, 16'h0005, 1'b0, 1'b1, '{16'h0002, 1'b1, 1'b0}};
    tbl[6] = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, '{16'h1001, 1'b0, 1'b0}};
    tbl[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
    tbl[8] = '{16'h0000, 16'h0000, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0}};
    tbl[9] = '{16'hABCD, 16'h1234, 1'b0, 1'b0, '{16'hBE01, 1'b0, 1'b0}};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    a   = '0;
    b   = '0;
    cin = 1'b0;
    sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_res_valid", 32'(res_valid), 32'd0);
    chk("post_rst_sum", 32'(sum), 32'd0);
    chk("post_rst_flags", 32'({cout, ovf}), 32'd0);

    for (int i = 0; i < 10; i++) send(tbl[i], 1'b1);
    drain();

    // backpressure: result held while a new command waits
    res_ready = 1'b0;
    v = '{16'h1234, 16'h1111, 1'b0, 1'b0, '{16'h2345, 1'b0, 1'b0}};
    send(v, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      a   = 16'h0002;
      b   = 16'h0003;
      cin = 1'b0;
      sub = 1'b0;
      @(negedge clk);
      chk("bp_sum", 32'(sum), 32'h2345);
      chk("bp_flags", 32'({cout, ovf}), 32'd0);
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_after_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("bp_after_res_valid", 32'(res_valid), 32'd0);
    q.push_back('{16'h0005, 1'b0, 1'b0});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    drain();

    // reset while RUN is at k=2
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    a   = 16'h1234;
    b   = 16'h0001;
    cin = 1'b0;
    sub = 1'b0;
    @(negedge clk);
    chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_cmd_ready_idle", 32'(cmd_ready), 32'd1);
    chk("mr_res_valid", 32'(res_valid), 32'd0);
    chk("mr_sum", 32'(sum), 32'd0);
    chk("mr_flags", 32'({cout, ovf}), 32'd0);
    v = '{16'h0001, 16'h0001, 1'b0, 1'b0, '{16'h0002, 1'b0, 1'b0}};
    send(v, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequencer that performs multi-word addition and subtraction on wide operands using a single 4-bit ripple adder (`parallel_adder_4`). It processes one nibble per cycle, least-significant first, and carries between nibbles in a register. The block sits between a requester with a valid/ready command port and a consumer with a valid/ready result port. It lets the design reuse one small adder instead of instantiating a wide one.

## Interface
- `NIBBLES`, default 4: operand width in nibbles. W = 4*NIBBLES. Legal range is 2..16.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `cmd_valid`, input, 1: requester presents an operation.
- `cmd_ready`, output, 1: block can accept an operation.
- `a`, input, W: operand A, sampled on command accept.
- `b`, input, W: operand B, sampled on command accept.
- `cin`, input, 1: carry-in for add; ignored when `sub`=1.
- `sub`, input, 1: 0 computes A+B+cin; 1 computes A−B.
- `res_valid`, output, 1: result is available.
- `res_ready`, input, 1: consumer takes the result.
- `sum`, output, W: result.
- `cout`, output, 1: carry out of the MSB nibble. For `sub`=1, it is the not-borrow flag (1 means A≥B unsigned).
- `ovf`, output, 1: two's-complement signed overflow.

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`: latch A into `a_r`; latch B into `b_r`, inverted when `sub`=1.
  - Seed the carry register: `carry_r` = `sub` ? 1 : `cin`.
  - Clear nibble index `k` to 0, then go to RUN.
- **RUN**
  - `cmd_ready`=0.
  - The adder inputs are `a_r[4k+3:4k]`, `b_r[4k+3:4k]` and `carry_r`.
  - The adder sum is written into `sum_r[4k+3:4k]`, and `carry_r` takes the adder carry-out.
  - If `k`==NIBBLES−1, go to DONE. Otherwise increment `k`.
- **DONE**
  - `res_valid`=1 and `cmd_ready`=0.
  - Hold `sum`, `cout` and `ovf` stable.
  - On `res_ready`=1, go to IDLE.
  - There is no same-cycle accept of a new command in DONE.
- **Result flags**
  - `cout` = `carry_r` after the final nibble.
  - `ovf` = (`a_r`[W−1] == `b_r`[W−1]) && (`sum_r`[W−1] != `a_r`[W−1]). Because `b_r` is already inverted for subtraction, this one expression covers both add and sub.
- **Ignored inputs**: `cmd_valid` outside IDLE is ignored. The requester must hold the command until it is accepted.
- **Arithmetic**: all arithmetic is modulo 2^W. The adder's internal carries are not observed; only its `cout` port is used.

## Timing
- Reset values: `cmd_ready`=0 during reset and 1 in the first cycle after reset. `res_valid`=0, `sum`=0, `cout`=0, `ovf`=0. State is IDLE and `k`=0.
- Latency:
  - Command accepted at edge T.
  - RUN occupies edges T+1 through T+NIBBLES.
  - `res_valid` rises after edge T+NIBBLES; with NIBBLES=4, it is visible in cycle T+5.
- Throughput: at best one operation per NIBBLES+2 cycles (accept, NIBBLES RUN cycles, one DONE handshake cycle).
- Backpressure: `res_valid` stays high and the outputs are frozen for any number of cycles while `res_ready`=0.
- Reset mid-operation, in RUN or DONE:
  - The next edge returns the block to IDLE and discards the partial result.
  - Outputs take their reset values, so no stale `res_valid` appears.
- Outputs `sum`, `cout` and `ovf` are registered. The adder path is the only combinational logic: nibble mux, then adder, then register.

## Structure
- Shared package `multiword_add_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the default NIBBLES constant;
  - the localparam width helper for `k`, which is $clog2(NIBBLES).
- Sub-module: one instance of `parallel_adder_4` as the shared datapath. The remaining logic (FSM, nibble mux and result register) is in this block.

## Test plan
- **Basic add**: NIBBLES=4, A=0x1234, B=0x4321, cin=0, sub=0 → `sum`=0x5555, `cout`=0, `ovf`=0, `res_valid` in cycle T+5.
- **Full carry ripple across nibbles**: A=0xFFFF, B=0x0001, cin=0 → `sum`=0x0000, `cout`=1, `ovf`=0.
- **Signed overflow and cin**:
  - A=0x7FFF, B=0x0000, cin=1 → `sum`=0x8000, `cout`=0, `ovf`=1.
  - A=0x8000, B=0x8000 → `sum`=0x0000, `cout`=1, `ovf`=1.
- **Subtract with borrow**: A=0x0005, B=0x0007, sub=1, cin=1 (must be ignored) → `sum`=0xFFFE, `cout`=0, `ovf`=0. Also A=0x0007, B=0x0005, sub=1 → `sum`=0x0002, `cout`=1.
- **Backpressure**:
  - Hold `res_ready`=0 for 3 cycles after `res_valid` while driving `cmd_valid`=1 with new operands.
  - Required: outputs stay stable, `cmd_ready`=0, and the new command is not accepted until the cycle after `res_ready`.
- **Reset mid-RUN**:
  - Assert `rst` for one cycle at RUN k=2.
  - Required: the next cycle shows IDLE, `cmd_ready`=1, `res_valid`=0, `sum`=0, `cout`=0, `ovf`=0.
  - A following add of 0x0001+0x0001 returns 0x0002.
